// File: rtl/relu_pool_pkg.sv
// Shared types and helpers for the ReLU + pooling engine.
package relu_pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int DW_DEF = 16;
   localparam int K_DEF  = 2;

   // Only power-of-two windows of 2 or 4 are supported by the shift-based average.
   function automatic bit k_legal(input int k);
      return (k == 2) || (k == 4);
   endfunction

   function automatic int log2k(input int k);
      return (k == 4) ? 2 : 1;
   endfunction

   // Sum of K*K DW-bit values needs 2*log2(K) guard bits.
   function automatic int acc_width(input int dw, input int k);
      return dw + 2 * log2k(k);
   endfunction

   localparam int ACC_W = DW_DEF + 2 * log2k(K_DEF);

endpackage

// File: rtl/relu_pool_engine_if.sv
// Stream/config bundle between the PE array side and the pooling engine.
interface relu_pool_engine_if #(
   parameter int DW     = 16,
   parameter int CH     = 4,
   parameter int FMAP_W = 5
);
   logic              start;
   logic [FMAP_W-1:0] featmap_size;
   logic              pool_mode;
   logic              relu_en;
   logic              in_valid;
   logic [CH*DW-1:0]  din;
   logic [CH*DW-1:0]  dout;
   logic              dout_valid;
   logic              frame_done;
   logic              busy;

   modport master (
      output start, featmap_size, pool_mode, relu_en, in_valid, din,
      input  dout, dout_valid, frame_done, busy
   );

   modport slave (
      input  start, featmap_size, pool_mode, relu_en, in_valid, din,
      output dout, dout_valid, frame_done, busy
   );
endinterface

// File: rtl/relu_pool_lane.sv
// One channel lane: ReLU, horizontal accumulator, column buffer, max/avg merge.
// The average path exists only when RELU_POOL_AVG_EN is defined.
module relu_pool_lane
   import relu_pool_pkg::*;
#(
   parameter int DW       = 16,
   parameter int K        = 2,
   parameter int MAX_FMAP = 28,
   parameter int IDX_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 relu_en,
   input  logic                 avg,
   input  logic                 en,
   input  logic                 c_first,
   input  logic                 c_last,
   input  logic                 r_first,
   input  logic                 r_last,
   input  logic [IDX_W-1:0]     idx,
   input  logic signed [DW-1:0] din,
   output logic signed [DW-1:0] dout
);
   localparam int LK      = log2k(K);
   localparam int AW      = acc_width(DW, K);
   localparam int ENTRIES = MAX_FMAP / K;

   typedef logic signed [AW-1:0] acc_t;

   acc_t              hacc;
   acc_t              col_buf [ENTRIES];
   acc_t              pix;
   acc_t              h_new;
   acc_t              e_new;
   logic signed [DW-1:0] res;

`ifndef RELU_POOL_AVG_EN
   logic unused_avg;
   assign unused_avg = avg;
`endif

   function automatic acc_t merge(input acc_t a, input acc_t b);
`ifdef RELU_POOL_AVG_EN
      if (avg) return a + b;
`endif
      return (a > b) ? a : b;
   endfunction

   // ReLU, window-row merge, column merge and final scaling
   always_comb begin
      pix   = (relu_en && din[DW-1]) ? '0 : acc_t'(din);
      h_new = c_first ? pix : merge(hacc, pix);
      e_new = r_first ? h_new : merge(col_buf[idx], h_new);
`ifdef RELU_POOL_AVG_EN
      res   = avg ? DW'(e_new >>> (2 * LK)) : DW'(e_new);
`else
      res   = DW'(e_new);
`endif
   end

   // Accumulator, column buffer and output register updates
   always_ff @(posedge clk) begin
      if (rst) begin
         hacc <= '0;
         dout <= '0;
         for (int i = 0; i < ENTRIES; i++) col_buf[i] <= '0;
      end else if (en) begin
         if (!c_last)
            hacc <= h_new;
         else if (!r_last)
            col_buf[idx] <= e_new;
         else
            dout <= res;
      end
   end

endmodule

// File: rtl/relu_pool_engine.sv
// Streaming ReLU + non-overlapping KxK pooling over CH parallel lanes.
// Optional feature macro: RELU_POOL_AVG_EN enables average pooling (pool_mode).
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no frame active, waiting for start with S >= 1
// ST_RUN  | consuming pixels of the current frame
module relu_pool_engine
   import relu_pool_pkg::*;
#(
   parameter int DW       = 16,
   parameter int CH       = 4,
   parameter int K        = 2,
   parameter int MAX_FMAP = 28,
   parameter int FMAP_W   = $clog2(MAX_FMAP + 1)
) (
   input  logic            clk,
   input  logic            rst,
   relu_pool_engine_if.slave bus
);
   localparam int LK         = log2k(K);
   localparam int IDX_W      = FMAP_W - LK;
   localparam int REGION_MAX = (MAX_FMAP / K) * K;

   if (!k_legal(K)) begin : g_bad_k
      $error("relu_pool_engine: K must be 2 or 4");
   end

   state_e            state;
   state_e            state_nxt;
   logic [FMAP_W-1:0] size_q;
   logic [FMAP_W-1:0] row;
   logic [FMAP_W-1:0] col;
   logic [FMAP_W-1:0] lim_floor;
   logic [FMAP_W-1:0] lim;
   logic              relu_q;
   logic              avg_sel;
   logic              start_ok;
   logic              accept;
   logic              in_region;
   logic              last_pix;
   logic              col_wrap;
   logic              lane_en;
   logic              c_first;
   logic              c_last;
   logic              r_first;
   logic              r_last;
   logic              dout_valid_q;
   logic              frame_done_q;
   logic signed [DW-1:0] lane_dout [CH];

`ifdef RELU_POOL_AVG_EN
   pool_mode_e mode_q;

   // Pooling mode is latched with the rest of the frame configuration
   always_ff @(posedge clk) begin
      if (rst)
         mode_q <= POOL_MAX;
      else if (start_ok)
         mode_q <= pool_mode_e'(bus.pool_mode);
   end

   assign avg_sel = (mode_q == POOL_AVG);
`else
   logic unused_pool_mode;
   assign unused_pool_mode = bus.pool_mode;
   assign avg_sel          = 1'b0;
`endif

   // Pixel acceptance, pooling-region and window-position decode
   always_comb begin
      start_ok  = bus.start && (bus.featmap_size != '0);
      accept    = (state == ST_RUN) && bus.in_valid && !start_ok;
      lim_floor = {size_q[FMAP_W-1:LK], {LK{1'b0}}};
      lim       = (lim_floor > FMAP_W'(REGION_MAX)) ? FMAP_W'(REGION_MAX) : lim_floor;
      in_region = (row < lim) && (col < lim);
      col_wrap  = (col == size_q - FMAP_W'(1));
      last_pix  = col_wrap && (row == size_q - FMAP_W'(1));
      c_first   = (col[LK-1:0] == '0);
      c_last    = (col[LK-1:0] == '1);
      r_first   = (row[LK-1:0] == '0);
      r_last    = (row[LK-1:0] == '1);
      lane_en   = accept && in_region;
   end

   // Next-state: a new start always restarts, the last pixel ends the frame
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_ok) state_nxt = ST_RUN;
         ST_RUN:  if (accept && last_pix) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Configuration latch and raster row/col counters
   always_ff @(posedge clk) begin
      if (rst) begin
         size_q <= '0;
         relu_q <= 1'b0;
         row    <= '0;
         col    <= '0;
      end else if (start_ok) begin
         size_q <= bus.featmap_size;
         relu_q <= bus.relu_en;
         row    <= '0;
         col    <= '0;
      end else if (accept) begin
         if (last_pix) begin
            row <= '0;
            col <= '0;
         end else if (col_wrap) begin
            col <= '0;
            row <= row + FMAP_W'(1);
         end else begin
            col <= col + FMAP_W'(1);
         end
      end
   end

   // Output strobes, one cycle after the completing pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         dout_valid_q <= lane_en && c_last && r_last;
         frame_done_q <= accept && last_pix;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      relu_pool_lane #(
         .DW       (DW),
         .K        (K),
         .MAX_FMAP (MAX_FMAP),
         .IDX_W    (IDX_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .relu_en (relu_q),
         .avg     (avg_sel),
         .en      (lane_en),
         .c_first (c_first),
         .c_last  (c_last),
         .r_first (r_first),
         .r_last  (r_last),
         .idx     (col[FMAP_W-1:LK]),
         .din     (bus.din[i*DW +: DW]),
         .dout    (lane_dout[i])
      );
   end

   // Pack lane results onto the output bus
   always_comb begin
      bus.dout = '0;
      for (int i = 0; i < CH; i++) bus.dout[i*DW +: DW] = lane_dout[i];
   end

   assign bus.dout_valid = dout_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = (state == ST_RUN);

endmodule

// File: tb/tb_relu_pool_engine.sv
// Scoreboard bench for relu_pool_engine: window results are computed from the
// stored frame when the completing pixel is driven, queued, and popped when
// the DUT presents dout_valid.
module tb_relu_pool_engine;
   import relu_pool_pkg::*;

   localparam int DW       = 16;
   localparam int CH       = 4;
   localparam int K        = 2;
   localparam int MAX_FMAP = 28;
   localparam int FMAP_W   = $clog2(MAX_FMAP + 1);
   localparam int SH       = 2 * log2k(K);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   relu_pool_engine_if #(.DW(DW), .CH(CH), .FMAP_W(FMAP_W)) bus ();

   relu_pool_engine #(
      .DW       (DW),
      .CH       (CH),
      .K        (K),
      .MAX_FMAP (MAX_FMAP),
      .FMAP_W   (FMAP_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [CH*DW-1:0] exp_q [$];
   logic [CH*DW-1:0] last_dout;
   int  pix [CH][MAX_FMAP][MAX_FMAP];
   bit  m_busy;
   bit  m_relu;
   bit  m_avg;
   int  m_s;
   int  m_r;
   int  m_c;
   int  n_out;
   int  first_out;
   int  second_out;
   int  last_out;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] window_res(input int lane, input int r0, input int c0);
      int v;
      int acc;
      int mx;
      acc = 0;
      mx  = -(1 << 30);
      for (int dr = 0; dr < K; dr++) begin
         for (int dc = 0; dc < K; dc++) begin
            v = pix[lane][r0 + dr][c0 + dc];
            if (m_relu && v < 0) v = 0;
            acc += v;
            if (v > mx) mx = v;
         end
      end
      if (m_avg) return DW'(acc >>> SH);
      return DW'(mx);
   endfunction

   function automatic logic [CH*DW-1:0] gen_pix(input int kind, input int r, input int c, input int s);
      logic [CH*DW-1:0] d;
      int idx;
      idx = r * s + c;
      d   = '0;
      for (int l = 0; l < CH; l++) begin
         case (kind)
            0: d[l*DW +: DW] = DW'(idx);
            1: begin
               case (l)
                  0: d[l*DW +: DW] = DW'(-5);
                  1: d[l*DW +: DW] = ((r % 2 == 0) && (c % 2 == 0)) ? DW'(-3) : DW'(0);
                  2: d[l*DW +: DW] = DW'($urandom);
                  default: d[l*DW +: DW] = DW'(-idx);
               endcase
            end
            default: d[l*DW +: DW] = DW'($urandom);
         endcase
      end
      return d;
   endfunction

   task automatic step(input bit st, input int sz, input bit pm, input bit re,
                       input bit iv, input logic [CH*DW-1:0] d);
      bit exp_v;
      bit exp_d;
      int lim;
      logic [CH*DW-1:0] e;
      exp_v = 1'b0;
      exp_d = 1'b0;
      e     = '0;
      if (st && sz != 0) begin
         m_busy = 1'b1;
         m_s    = sz;
         m_relu = re;
`ifdef RELU_POOL_AVG_EN
         m_avg  = pm;
`else
         m_avg  = 1'b0;
`endif
         m_r    = 0;
         m_c    = 0;
      end else if (m_busy && iv) begin
         for (int l = 0; l < CH; l++) pix[l][m_r][m_c] = int'($signed(d[l*DW +: DW]));
         lim = (m_s / K) * K;
         if (m_r < lim && m_c < lim && (m_r % K) == K - 1 && (m_c % K) == K - 1) begin
            for (int l = 0; l < CH; l++) e[l*DW +: DW] = window_res(l, m_r - K + 1, m_c - K + 1);
            exp_q.push_back(e);
            exp_v = 1'b1;
         end
         if (m_r == m_s - 1 && m_c == m_s - 1) begin
            exp_d  = 1'b1;
            m_busy = 1'b0;
         end else if (m_c == m_s - 1) begin
            m_c = 0;
            m_r++;
         end else begin
            m_c++;
         end
      end
      bus.start        = st;
      bus.featmap_size = FMAP_W'(sz);
      bus.pool_mode    = pm;
      bus.relu_en      = re;
      bus.in_valid     = iv;
      bus.din          = d;
      @(posedge clk);
      #1;
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("frame_done", 64'(bus.frame_done), 64'(exp_d));
      chk("dout_valid", 64'(bus.dout_valid), 64'(exp_v));
      if (bus.dout_valid) begin
         n_out++;
         if (n_out == 1) first_out = int'($signed(bus.dout[DW-1:0]));
         if (n_out == 2) second_out = int'($signed(bus.dout[DW-1:0]));
         last_out = int'($signed(bus.dout[DW-1:0]));
      end
      if (exp_v) begin
         e = exp_q.pop_front();
         if (bus.dout_valid) chk("dout", 64'(bus.dout), 64'(e));
         last_dout = e;
      end else begin
         chk("dout_hold", 64'(bus.dout), 64'(last_dout));
      end
   endtask

   task automatic run_frame(input int s, input bit pm, input bit re, input int kind,
                            input bit gaps, input int stop_after);
      int n;
      bit iv;
      logic [CH*DW-1:0] d;
      n = 0;
      // start together with in_valid: the pixel must not be consumed
      step(1'b1, s, pm, re, 1'b1, gen_pix(2, 0, 0, 1));
      n_out = 0;
      while (n < s * s && !(stop_after > 0 && n == stop_after)) begin
         iv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         d  = iv ? gen_pix(kind, n / s, n % s, s) : gen_pix(2, 0, 0, 1);
         step(1'b0, 0, ~pm, ~re, iv, d);
         if (iv) n++;
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      m_busy    = 1'b0;
      last_dout = '0;
      exp_q.delete();
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_dout", 64'(bus.dout), 64'(0));
      chk("rst_dout_valid", 64'(bus.dout_valid), 64'(0));
      chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
   endtask

   initial begin
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.featmap_size = '0;
      bus.pool_mode    = 1'b0;
      bus.relu_en      = 1'b0;
      bus.in_valid     = 1'b0;
      bus.din          = '0;
      m_busy = 1'b0; m_relu = 1'b0; m_avg = 1'b0;
      m_s = 0; m_r = 0; m_c = 0;
      n_out = 0; first_out = 0; second_out = 0; last_out = 0;
      last_dout = '0;

      do_reset();

      // in_valid while idle and start with S = 0 are both ignored
      step(1'b0, 0, 1'b0, 1'b0, 1'b1, gen_pix(2, 0, 0, 1));
      step(1'b0, 0, 1'b0, 1'b0, 1'b1, gen_pix(2, 0, 0, 1));
      step(1'b1, 0, 1'b0, 1'b1, 1'b1, gen_pix(2, 0, 0, 1));

      run_frame(28, 1'b0, 1'b1, 0, 1'b0, 0);
      chk("ramp28_count", 64'(n_out), 64'(196));
      chk("ramp28_first", 64'(first_out), 64'(29));
      chk("ramp28_last", 64'(last_out), 64'(783));

      run_frame(28, 1'b1, 1'b1, 0, 1'b0, 0);
`ifdef RELU_POOL_AVG_EN
      chk("avg28_first", 64'(first_out), 64'(14));
      chk("avg28_second", 64'(second_out), 64'(16));
`else
      chk("avg28_first", 64'(first_out), 64'(29));
      chk("avg28_second", 64'(second_out), 64'(31));
`endif

      run_frame(8, 1'b0, 1'b1, 1, 1'b0, 0);
      run_frame(8, 1'b0, 1'b0, 1, 1'b0, 0);
      run_frame(8, 1'b1, 1'b0, 1, 1'b0, 0);

      run_frame(5, 1'b0, 1'b1, 0, 1'b0, 0);
      chk("s5_count", 64'(n_out), 64'(4));
      chk("s5_first", 64'(first_out), 64'(6));
      chk("s5_last", 64'(last_out), 64'(18));

      run_frame(1, 1'b0, 1'b0, 2, 1'b0, 0);
      chk("s1_count", 64'(n_out), 64'(0));
      run_frame(3, 1'b1, 1'b0, 2, 1'b0, 0);
      chk("s3_count", 64'(n_out), 64'(1));

      run_frame(28, 1'b0, 1'b1, 0, 1'b1, 0);
      chk("gaps_count", 64'(n_out), 64'(196));
      chk("gaps_last", 64'(last_out), 64'(783));

      run_frame(28, 1'b0, 1'b1, 0, 1'b0, 100);
      run_frame(28, 1'b1, 1'b0, 2, 1'b1, 0);
      chk("restart_count", 64'(n_out), 64'(196));

      run_frame(12, 1'b0, 1'b0, 2, 1'b0, 50);
      do_reset();
      run_frame(12, 1'b1, 1'b1, 2, 1'b1, 0);
      chk("after_rst_count", 64'(n_out), 64'(36));

      for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1, gen_pix(2, 0, 0, 1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/relu_pool_engine.md
# relu_pool_engine

Streaming ReLU + non-overlapping pooling stage for the convolution datapath. It is the parametrised successor of the single-channel 2x2 ReLU/max-pool stage. It processes CH channels in parallel lanes, supports pool size K in {2,4} with stride K, and offers runtime selection of max or average pooling with optional ReLU. It sits between the PE array output and the feature-map write-back FIFO. It takes one raster-ordered square feature map per frame.

## Interface
- DW, 16: signed data width per channel.
- CH, 4: parallel channel lanes.
- K, 2: pool window and stride; legal values 2 or 4.
- MAX_FMAP, 28: largest supported feature-map side.
- FMAP_W, $clog2(MAX_FMAP+1): width of featmap_size.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches configuration and begins a frame.
- featmap_size  in  FMAP_W  side length S; sampled only on start.
- pool_mode  in  1  0 = max, 1 = average; sampled on start.
- relu_en  in  1  1 = clamp negatives to 0 before pooling; sampled on start.
- in_valid  in  1  din carries one pixel (all lanes) this cycle.
- din  in  CH*DW  lane i at [i*DW +: DW], two's complement.
- dout  out  CH*DW  pooled result per lane.
- dout_valid  out  1  dout valid for exactly this cycle.
- frame_done  out  1  one-cycle pulse at frame end.
- busy  out  1  frame in progress.

## Operation
- Idle → start with S ≥ 1: latch S, mode and relu_en; clear row/col counters; busy=1 from the next cycle.
- start with S = 0 is ignored.
- Pixels are consumed only while busy and in_valid. in_valid while idle is ignored. No backpressure exists.
- Counters: col c runs 0..S-1, then wraps and increments row r. The pixel at (S-1, S-1) ends the frame.
- Pooling region is floor(S/K)*K square. Pixels with r or c ≥ floor(S/K)*K are consumed and discarded. If S < K, the frame produces no outputs.
- ReLU (when relu_en=1) is applied per lane before pooling. When relu_en=0, values pool as signed.
- Per lane: a horizontal accumulator combines the K pixels of a window row.
  - At c%K = K-1 the row result merges into a column buffer entry indexed c/K, which has MAX_FMAP/K entries.
  - The entry is initialised when r%K = 0, not merged.
  - At r%K = K-1 the merged value is emitted.
- Max mode uses a signed compare.
- Average mode sums K*K values at width DW + 2*log2(K), then applies an arithmetic right shift by 2*log2(K), i.e. floor. The result always fits DW.
- start while busy aborts the current frame: no frame_done is issued for it, and the new frame begins with fresh configuration.
- start and in_valid in the same cycle: start wins and that pixel is not consumed.

## Timing
- dout_valid is asserted the cycle after the window-completing pixel is accepted (latency 1). dout holds its value until the next dout_valid.
- frame_done is asserted the cycle after pixel (S-1, S-1) is accepted, coincident with the last dout_valid when applicable. busy falls in the same cycle.
- Throughput is one pixel per cycle per lane, with no stall between frames. start may be issued in the cycle frame_done is high.
- Reset values: dout=0, dout_valid=0, frame_done=0, busy=0. Counters, accumulators and the column buffer are cleared.
- rst mid-frame takes effect on the next edge and drops all partial windows.

## Configuration
- RELU_POOL_AVG_EN defined: adders, shifters and pool_mode are implemented as described.
- RELU_POOL_AVG_EN undefined: the average path is removed, pool_mode is ignored and max pooling is always used. All other behaviour is identical.

## Structure
- Package relu_pool_pkg holds:
  - pool_mode_e (POOL_MAX=0, POOL_AVG=1);
  - the legal-K check;
  - function log2k(K);
  - localparam ACC_W = DW + 2*log2k(K).
- Sub-module relu_pool_lane: one lane holding ReLU, horizontal accumulator, column buffer, and max/avg merge. It is instantiated CH times.
- Top level holds the row/col counters, start/abort FSM (IDLE, RUN), and valid/done generation.

## Test plan
- S=28, K=2, max, relu_en=1, din = ramp 0..783 on all lanes, continuous in_valid → 196 outputs. First = 29, last = 783. frame_done one cycle after pixel 783.
- Same stimulus, pool_mode=avg → first output (0+1+28+29)>>2 = 14, second = (2+3+30+31)>>2 = 16.
- Lane 0 constant -5 → relu_en=1: all 0; relu_en=0 max: -5; relu_en=0 avg: -5. Lane 1 value -3 with neighbours 0 (relu_en=0 avg) → floor(-3/4) = -1.
- S=5, K=2, ramp → 4 outputs (6, 8, 16, 18); row 4 and column 4 discarded. frame_done after 25th pixel.
- Random in_valid gaps with the case-1 stimulus → identical output sequence. start re-issued after 100 pixels → no frame_done for the aborted frame, and the new frame is correct.
- rst asserted mid-frame → next cycle busy=0, dout=0, dout_valid=0. A following full frame is correct.
